// File: rtl/dsc_mul_seq_if.sv
// Handshake and multiplier-side bus of the stochastic multiplier sequencer.
// "master" is the sequencer's view; "slave" is the environment's view
// (operand producer, multiplier datapath and result consumer).
interface dsc_mul_seq_if #(
    parameter int SNG_WIDTH  = 10,
    parameter int NUM_INPUTS = 2
);
    localparam int ZW = NUM_INPUTS * SNG_WIDTH;

    logic                 in_valid;
    logic                 in_ready;
    logic [SNG_WIDTH-1:0] in_a;
    logic [SNG_WIDTH-1:0] in_b;
    logic [SNG_WIDTH-1:0] mul_a;
    logic [SNG_WIDTH-1:0] mul_b;
    logic                 mul_en;
    logic                 mul_clr;
    logic [ZW-1:0]        mul_z;
    logic                 mul_ov;
    logic                 out_valid;
    logic                 out_ready;
    logic [ZW-1:0]        out_z;
    logic [ZW:0]          out_cycles;
    logic                 out_timeout;

    modport master (
        input  in_valid, in_a, in_b, mul_z, mul_ov, out_ready,
        output in_ready, mul_a, mul_b, mul_en, mul_clr,
               out_valid, out_z, out_cycles, out_timeout
    );

    modport slave (
        output in_valid, in_a, in_b, mul_z, mul_ov, out_ready,
        input  in_ready, mul_a, mul_b, mul_en, mul_clr,
               out_valid, out_z, out_cycles, out_timeout
    );
endinterface

// File: rtl/dsc_mul_seq.sv
// Sequencer for a stochastic (SNG-based) multiplier. It latches an operand
// pair, clears the multiplier counters, streams until the multiplier reports
// done or a watchdog expires, lets the last stream bit settle, then holds the
// captured product count until the consumer takes it. Zero operands skip the
// multiplier entirely since the product is known to be zero.
module dsc_mul_seq #(
    parameter int              SNG_WIDTH  = 10,
    parameter int              NUM_INPUTS = 2,
    parameter longint unsigned MAX_CYCLES = 64'd1 << (NUM_INPUTS * SNG_WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    dsc_mul_seq_if.master bus
);
    localparam int          ZW        = NUM_INPUTS * SNG_WIDTH;
    localparam logic [ZW:0] CYC_LIMIT = (ZW+1)'(MAX_CYCLES - 64'd1);
    localparam logic [ZW:0] CYC_ONE   = (ZW+1)'(1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        DRAIN,
        HOLD
    } state_t;

    state_t               state_q;
    logic [SNG_WIDTH-1:0] mul_a_q;
    logic [SNG_WIDTH-1:0] mul_b_q;
    logic                 mul_en_q;
    logic                 mul_clr_q;
    logic                 in_ready_q;
    logic                 out_valid_q;
    logic [ZW-1:0]        out_z_q;
    logic [ZW:0]          out_cycles_q;
    logic                 out_timeout_q;
    logic [ZW:0]          cycle_cnt_q;
    logic [ZW:0]          cycle_cnt_d;
    logic                 timeout_q;
    logic                 limit_hit;

    // Next value of the RUN cycle counter and watchdog-limit detection.
    always_comb begin
        cycle_cnt_d = cycle_cnt_q + CYC_ONE;
        limit_hit   = (cycle_cnt_q == CYC_LIMIT);
    end

    // Sequencer FSM; every output is a register so the multiplier sees clean levels.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            mul_a_q       <= '0;
            mul_b_q       <= '0;
            mul_en_q      <= 1'b0;
            mul_clr_q     <= 1'b0;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            out_z_q       <= '0;
            out_cycles_q  <= '0;
            out_timeout_q <= 1'b0;
            cycle_cnt_q   <= '0;
            timeout_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        mul_a_q    <= bus.in_a;
                        mul_b_q    <= bus.in_b;
                        in_ready_q <= 1'b0;
                        if ((bus.in_a == '0) || (bus.in_b == '0)) begin
                            state_q       <= HOLD;
                            out_valid_q   <= 1'b1;
                            out_z_q       <= '0;
                            out_cycles_q  <= '0;
                            out_timeout_q <= 1'b0;
                        end else begin
                            state_q   <= CLEAR;
                            mul_clr_q <= 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    state_q     <= RUN;
                    mul_clr_q   <= 1'b0;
                    mul_en_q    <= 1'b1;
                    cycle_cnt_q <= '0;
                    timeout_q   <= 1'b0;
                end
                RUN: begin
                    cycle_cnt_q <= cycle_cnt_d;
                    if (bus.mul_ov) begin
                        state_q   <= DRAIN;
                        mul_en_q  <= 1'b0;
                        timeout_q <= 1'b0;
                    end else if (limit_hit) begin
                        state_q   <= DRAIN;
                        mul_en_q  <= 1'b0;
                        timeout_q <= 1'b1;
                    end
                end
                DRAIN: begin
                    state_q       <= HOLD;
                    out_valid_q   <= 1'b1;
                    out_z_q       <= bus.mul_z;
                    out_cycles_q  <= cycle_cnt_q;
                    out_timeout_q <= timeout_q;
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    mul_en_q   <= 1'b0;
                    mul_clr_q  <= 1'b0;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.mul_a       = mul_a_q;
    assign bus.mul_b       = mul_b_q;
    assign bus.mul_en      = mul_en_q;
    assign bus.mul_clr     = mul_clr_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_z       = out_z_q;
    assign bus.out_cycles  = out_cycles_q;
    assign bus.out_timeout = out_timeout_q;
endmodule

// File: tb/tb_dsc_mul_seq.sv
// Testbench for dsc_mul_seq. A behavioural multiplier stand-in counts enabled
// stream cycles and raises mul_ov on a chosen cycle; expected results are
// queued when operands are sent and popped when the result appears.
module tb_dsc_mul_seq;
    localparam int SW   = 10;
    localparam int NI   = 2;
    localparam int ZW   = SW * NI;
    localparam int MAXC = 16;

    typedef struct {
        logic [ZW-1:0] z;
        logic [ZW:0]   cyc;
        logic          to;
        int            lat;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    int            compared   = 0;
    int            mismatched = 0;
    exp_t          sbq[$];

    logic [ZW-1:0] enCnt;
    int            kTarget = 0;
    bit            ovArm   = 1'b0;
    bit            ovForce = 1'b0;
    logic [ZW-1:0] zOff    = '0;
    int            clrCycles = 0;
    int            enCycles  = 0;

    dsc_mul_seq_if #(.SNG_WIDTH(SW), .NUM_INPUTS(NI)) bus ();

    dsc_mul_seq #(
        .SNG_WIDTH (SW),
        .NUM_INPUTS(NI),
        .MAX_CYCLES(MAXC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Multiplier stand-in: counts enabled stream cycles since the last clear.
    always @(posedge clk) begin
        if (rst || bus.mul_clr) enCnt <= '0;
        else if (bus.mul_en) enCnt <= enCnt + 1'b1;
    end

    // Pulse counters used to prove clear/enable activity (or its absence).
    always @(posedge clk) begin
        if (bus.mul_clr === 1'b1) clrCycles <= clrCycles + 1;
        if (bus.mul_en === 1'b1) enCycles <= enCycles + 1;
    end

    assign bus.mul_ov = ovForce | (ovArm & (bus.mul_en === 1'b1) & (int'(enCnt) == kTarget - 1));
    assign bus.mul_z  = enCnt + zOff;

    // Expected result from the sequencing rules: done on cycle k, else watchdog.
    function automatic exp_t expectFor(input int a, input int b, input int k, input bit armed,
                                       input logic [ZW-1:0] off);
        exp_t e;
        int   runs;
        bit   early;
        if (a == 0 || b == 0) begin
            e.z = '0; e.cyc = '0; e.to = 1'b0; e.lat = 1;
        end else begin
            early = armed && (k >= 1) && (k <= MAXC);
            runs  = early ? k : MAXC;
            e.z   = ZW'(runs) + off;
            e.cyc = (ZW+1)'(runs);
            e.to  = !early;
            e.lat = runs + 3;
        end
        return e;
    endfunction

    // Offer operands until the DUT is ready; returns after the accepting edge.
    task automatic sendOperands(input int a, input int b, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_a     = SW'(a);
        bus.in_b     = SW'(b);
        for (int i = 0; i < 50; i++) begin
            if (bus.in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) @(posedge clk);
        else bus.in_valid = 1'b0;
    endtask

    // Count edges after acceptance until out_valid is seen, recording early pulses.
    task automatic waitResult(output int lat, output logic [ZW-1:0] z, output logic [ZW:0] cyc,
                              output logic to, output logic clr1, output logic en1,
                              output logic en2, output bit ok);
        lat = 0; z = '0; cyc = '0; to = 1'b0; clr1 = 1'b0; en1 = 1'b0; en2 = 1'b0; ok = 1'b0;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (n == 1) begin
                bus.in_valid = 1'b0;
                clr1 = bus.mul_clr;
                en1  = bus.mul_en;
            end
            if (n == 2) en2 = bus.mul_en;
            if (bus.out_valid === 1'b1) begin
                lat = n; z = bus.out_z; cyc = bus.out_cycles; to = bus.out_timeout; ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        compared++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.mul_en !== 1'b0 || bus.mul_clr !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_ctrl: got rdy=%b vld=%b en=%b clr=%b expected 1 0 0 0",
                     bus.in_ready, bus.out_valid, bus.mul_en, bus.mul_clr);
        end
        compared++;
        if (bus.mul_a !== '0 || bus.mul_b !== '0 || bus.out_z !== '0 || bus.out_cycles !== '0 || bus.out_timeout !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_data: got a=%0d b=%0d z=%0d cyc=%0d to=%b expected all zero",
                     bus.mul_a, bus.mul_b, bus.out_z, bus.out_cycles, bus.out_timeout);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int aTab[4] = '{512, 3, 1023, 77};
        int bTab[4] = '{256, 5, 1023, 600};
        int kTab[4] = '{12, 1, 15, 7};
        exp_t e; bit ok; int lat, clrBefore;
        logic [ZW-1:0] z; logic [ZW:0] cyc; logic to, clr1, en1, en2;
        for (int i = 0; i < 4; i++) begin
            kTarget = kTab[i]; ovArm = 1'b1; zOff = ZW'($urandom_range(0, 500));
            sbq.push_back(expectFor(aTab[i], bTab[i], kTab[i], 1'b1, zOff));
            clrBefore = clrCycles;
            sendOperands(aTab[i], bTab[i], ok);
            waitResult(lat, z, cyc, to, clr1, en1, en2, ok);
            e = sbq.pop_front();
            compared++;
            if (!ok || lat != e.lat) begin
                mismatched++; $display("[TB] FAIL basic_latency[%0d]: got %0d expected %0d", i, lat, e.lat);
            end
            compared++;
            if (z !== e.z || cyc !== e.cyc || to !== e.to) begin
                mismatched++;
                $display("[TB] FAIL basic_result[%0d]: got z=%0d cyc=%0d to=%b expected z=%0d cyc=%0d to=%b",
                         i, z, cyc, to, e.z, e.cyc, e.to);
            end
            compared++;
            if (clr1 !== 1'b1 || en1 !== 1'b0 || en2 !== 1'b1 || clrCycles - clrBefore != 1) begin
                mismatched++;
                $display("[TB] FAIL basic_clear_seq[%0d]: got clr1=%b en1=%b en2=%b clrs=%0d expected 1 0 1 1",
                         i, clr1, en1, en2, clrCycles - clrBefore);
            end
            compared++;
            if (bus.mul_a !== SW'(aTab[i]) || bus.mul_b !== SW'(bTab[i])) begin
                mismatched++;
                $display("[TB] FAIL basic_operands[%0d]: got %0d,%0d expected %0d,%0d",
                         i, bus.mul_a, bus.mul_b, aTab[i], bTab[i]);
            end
        end
    endtask

    task automatic test_zero();
        int aTab[3] = '{0, 5, 0};
        int bTab[3] = '{700, 0, 0};
        exp_t e; bit ok; int lat, clrBefore, enBefore;
        logic [ZW-1:0] z; logic [ZW:0] cyc; logic to, clr1, en1, en2;
        for (int i = 0; i < 3; i++) begin
            kTarget = 3; ovArm = 1'b1;
            sbq.push_back(expectFor(aTab[i], bTab[i], 3, 1'b1, zOff));
            clrBefore = clrCycles; enBefore = enCycles;
            sendOperands(aTab[i], bTab[i], ok);
            waitResult(lat, z, cyc, to, clr1, en1, en2, ok);
            e = sbq.pop_front();
            compared++;
            if (!ok || lat != e.lat || z !== e.z || cyc !== e.cyc || to !== e.to) begin
                mismatched++;
                $display("[TB] FAIL zero_result[%0d]: got lat=%0d z=%0d cyc=%0d to=%b expected lat=%0d z=0 cyc=0 to=0",
                         i, lat, z, cyc, to, e.lat);
            end
            compared++;
            if (clrCycles != clrBefore || enCycles != enBefore) begin
                mismatched++;
                $display("[TB] FAIL zero_no_pulse[%0d]: got clr=%0d en=%0d cycles expected 0 0",
                         i, clrCycles - clrBefore, enCycles - enBefore);
            end
        end
    endtask

    task automatic test_watchdog();
        bit   armTab[3] = '{1'b0, 1'b1, 1'b1};
        int   kTab[3]   = '{0, MAXC, MAXC + 4};
        exp_t e; bit ok; int lat;
        logic [ZW-1:0] z; logic [ZW:0] cyc; logic to, clr1, en1, en2;
        for (int i = 0; i < 3; i++) begin
            kTarget = kTab[i]; ovArm = armTab[i]; zOff = ZW'($urandom_range(0, 500));
            sbq.push_back(expectFor(9, 13, kTab[i], armTab[i], zOff));
            sendOperands(9, 13, ok);
            waitResult(lat, z, cyc, to, clr1, en1, en2, ok);
            e = sbq.pop_front();
            compared++;
            if (!ok || lat != e.lat || cyc !== e.cyc) begin
                mismatched++;
                $display("[TB] FAIL watchdog_cycles[%0d]: got lat=%0d cyc=%0d expected lat=%0d cyc=%0d",
                         i, lat, cyc, e.lat, e.cyc);
            end
            compared++;
            if (to !== e.to || z !== e.z) begin
                mismatched++;
                $display("[TB] FAIL watchdog_flag[%0d]: got to=%b z=%0d expected to=%b z=%0d",
                         i, to, z, e.to, e.z);
            end
        end
    endtask

    task automatic test_hold_stall();
        exp_t e, e2; bit ok; int lat;
        logic [ZW-1:0] z; logic [ZW:0] cyc; logic to, clr1, en1, en2;
        @(negedge clk);
        ovForce = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            compared++;
            if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.mul_clr !== 1'b0 || bus.mul_en !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL idle_ov_ignored[%0d]: got rdy=%b vld=%b clr=%b en=%b expected 1 0 0 0",
                         i, bus.in_ready, bus.out_valid, bus.mul_clr, bus.mul_en);
            end
        end
        ovForce = 1'b0;
        bus.out_ready = 1'b0; kTarget = 5; ovArm = 1'b1; zOff = ZW'($urandom_range(0, 500));
        sbq.push_back(expectFor(3, 4, 5, 1'b1, zOff));
        sendOperands(3, 4, ok);
        waitResult(lat, z, cyc, to, clr1, en1, en2, ok);
        e = sbq.pop_front();
        compared++;
        if (!ok || z !== e.z || cyc !== e.cyc || to !== e.to) begin
            mismatched++;
            $display("[TB] FAIL stall_result: got z=%0d cyc=%0d to=%b expected z=%0d cyc=%0d to=%b",
                     z, cyc, to, e.z, e.cyc, e.to);
        end
        bus.in_valid = 1'b1; bus.in_a = SW'(9); bus.in_b = SW'(9); ovForce = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            compared++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_z !== e.z || bus.out_cycles !== e.cyc
                || bus.out_timeout !== e.to || bus.mul_a !== SW'(3)) begin
                mismatched++;
                $display("[TB] FAIL stall_hold[%0d]: got vld=%b rdy=%b z=%0d cyc=%0d to=%b a=%0d expected 1 0 %0d %0d %b 3",
                         i, bus.out_valid, bus.in_ready, bus.out_z, bus.out_cycles, bus.out_timeout,
                         bus.mul_a, e.z, e.cyc, e.to);
            end
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        compared++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.mul_a !== SW'(3)) begin
            mismatched++;
            $display("[TB] FAIL stall_release: got rdy=%b vld=%b a=%0d expected 1 0 3",
                     bus.in_ready, bus.out_valid, bus.mul_a);
        end
        ovForce = 1'b0; kTarget = 4; zOff = ZW'($urandom_range(0, 500));
        sbq.push_back(expectFor(9, 9, 4, 1'b1, zOff));
        @(posedge clk);
        waitResult(lat, z, cyc, to, clr1, en1, en2, ok);
        e2 = sbq.pop_front();
        compared++;
        if (!ok || bus.mul_a !== SW'(9) || lat != e2.lat || z !== e2.z || cyc !== e2.cyc) begin
            mismatched++;
            $display("[TB] FAIL stall_next: got a=%0d lat=%0d z=%0d cyc=%0d expected a=9 lat=%0d z=%0d cyc=%0d",
                     bus.mul_a, lat, z, cyc, e2.lat, e2.z, e2.cyc);
        end
    endtask

    task automatic test_reset_priority();
        exp_t e; bit ok; int lat;
        logic [ZW-1:0] z; logic [ZW:0] cyc; logic to, clr1, en1, en2;
        kTarget = 10; ovArm = 1'b1;
        sendOperands(7, 11, ok);
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            if (n == 1) bus.in_valid = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        compared++;
        if (bus.mul_en !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.mul_a !== '0
            || bus.out_cycles !== '0) begin
            mismatched++;
            $display("[TB] FAIL reset_in_run: got en=%b vld=%b rdy=%b a=%0d cyc=%0d expected 0 0 1 0 0",
                     bus.mul_en, bus.out_valid, bus.in_ready, bus.mul_a, bus.out_cycles);
        end
        rst = 1'b0;
        bus.out_ready = 1'b0; kTarget = 2;
        sendOperands(5, 6, ok);
        waitResult(lat, z, cyc, to, clr1, en1, en2, ok);
        rst = 1'b1;
        @(negedge clk);
        compared++;
        if (!ok || bus.out_valid !== 1'b0 || bus.out_z !== '0 || bus.in_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL reset_in_hold: got vld=%b z=%0d rdy=%b expected 0 0 1",
                     bus.out_valid, bus.out_z, bus.in_ready);
        end
        rst = 1'b0; bus.out_ready = 1'b1; kTarget = 3; zOff = ZW'($urandom_range(0, 500));
        sbq.push_back(expectFor(12, 13, 3, 1'b1, zOff));
        sendOperands(12, 13, ok);
        waitResult(lat, z, cyc, to, clr1, en1, en2, ok);
        e = sbq.pop_front();
        compared++;
        if (clr1 !== 1'b1 || en1 !== 1'b0 || en2 !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL post_reset_clear: got clr1=%b en1=%b en2=%b expected 1 0 1", clr1, en1, en2);
        end
        compared++;
        if (!ok || lat != e.lat || z !== e.z || cyc !== e.cyc) begin
            mismatched++;
            $display("[TB] FAIL post_reset_result: got lat=%0d z=%0d cyc=%0d expected lat=%0d z=%0d cyc=%0d",
                     lat, z, cyc, e.lat, e.z, e.cyc);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e; bit ok; int lat, a, b, k;
        logic [ZW-1:0] z; logic [ZW:0] cyc; logic to, clr1, en1, en2;
        for (int i = 0; i < 6; i++) begin
            a = $urandom_range(0, 1023); b = $urandom_range(1, 1023); k = $urandom_range(1, MAXC + 3);
            kTarget = k; ovArm = 1'b1; zOff = ZW'($urandom_range(0, 1000));
            sbq.push_back(expectFor(a, b, k, 1'b1, zOff));
            sendOperands(a, b, ok);
            waitResult(lat, z, cyc, to, clr1, en1, en2, ok);
            e = sbq.pop_front();
            compared++;
            if (!ok || lat != e.lat || z !== e.z || cyc !== e.cyc || to !== e.to) begin
                mismatched++;
                $display("[TB] FAIL b2b[%0d]: got lat=%0d z=%0d cyc=%0d to=%b expected lat=%0d z=%0d cyc=%0d to=%b",
                         i, lat, z, cyc, to, e.lat, e.z, e.cyc, e.to);
            end
        end
    endtask

    // Scenario sequence followed by the summary line.
    initial begin
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b1;
        rst           = 1'b1;
        test_reset();
        test_basic();
        test_zero();
        test_watchdog();
        test_hold_stall();
        test_reset_priority();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Global time limit so a stuck handshake cannot hang the run.
    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation did not complete, %0d compared", compared);
        $fatal(1, "[TB] time limit reached");
    end
endmodule

// File: doc/dsc_mul_seq.md
DSC_MUL_SEQ -- requirements
Module: dsc_mul_seq

Interface
REQ-001 Parameter SNG_WIDTH, default 10, operand width in bits.
REQ-002 Parameter NUM_INPUTS, default 2, number of multiplied operands; product width is ZW = NUM_INPUTS*SNG_WIDTH.
REQ-003 Parameter MAX_CYCLES, default 2**ZW, watchdog limit on RUN cycles.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  operand pair offered.
REQ-007 in_ready  output  1  sequencer can accept operands.
REQ-008 in_a, in_b  input  SNG_WIDTH each  binary operands.
REQ-009 mul_a, mul_b  output  SNG_WIDTH each  latched operands driven to the multiplier.
REQ-010 mul_en  output  1  multiplier stream enable.
REQ-011 mul_clr  output  1  one-cycle synchronous clear to the multiplier's SNG and stoch-to-binary counters.
REQ-012 mul_z  input  ZW  multiplier binary product count.
REQ-013 mul_ov  input  1  multiplier early-shutoff/done flag.
REQ-014 out_valid  output  1  result held.
REQ-015 out_ready  input  1  consumer accepts result.
REQ-016 out_z  output  ZW  captured product.
REQ-017 out_cycles  output  ZW+1  RUN cycles spent on this product.
REQ-018 out_timeout  output  1  result was forced by the watchdog.

Function
REQ-019 The block SHALL implement the states IDLE, CLEAR, RUN, DRAIN and HOLD.
REQ-020 IDLE: in_ready=1; on in_valid=1 the block SHALL latch in_a/in_b into mul_a/mul_b and go to CLEAR, or to HOLD when either operand is zero.
REQ-021 Zero shortcut: when an operand is zero, the block SHALL go IDLE->HOLD with out_z=0, out_cycles=0, out_timeout=0, and SHALL NOT assert mul_clr or mul_en.
REQ-022 CLEAR: mul_clr=1 and mul_en=0 for exactly one cycle, then RUN.
REQ-023 RUN: mul_en=1; the cycle counter SHALL start at 0 on RUN entry and increment once per RUN cycle.
REQ-024 In RUN with mul_ov=1, the block SHALL go to DRAIN; mul_en SHALL deassert in the next cycle.
REQ-025 In RUN with cycle counter = MAX_CYCLES-1 and mul_ov=0, the block SHALL go to DRAIN with the timeout flag set; if mul_ov=1 in the same cycle, the block SHALL NOT set timeout.
REQ-026 DRAIN: mul_en=0 for one cycle so the final stream bit is counted; at the end of DRAIN the block SHALL capture mul_z into out_z and the counter into out_cycles, then go to HOLD.
REQ-027 HOLD: out_valid=1, and out_z/out_cycles/out_timeout SHALL stay stable until out_valid&out_ready, then the block SHALL go to IDLE.
REQ-028 in_ready SHALL be 0 in every state except IDLE; operands offered outside IDLE SHALL be ignored.
REQ-029 Latency: for an operand pair accepted at edge T with mul_ov first high in RUN cycle k (k>=1), out_valid SHALL rise at edge T+k+3.
REQ-030 mul_a/mul_b SHALL change only on IDLE acceptance.
REQ-031 mul_ov SHALL be ignored outside RUN.

Reset
REQ-032 With rst=1 at an edge, the block SHALL enter IDLE and set in_ready=1, out_valid=0, mul_en=0, mul_clr=0, mul_a=mul_b=0, out_z=0, out_cycles=0, out_timeout=0, and clear the cycle counter.
REQ-033 rst SHALL take priority over every other input in every state, including mid-RUN and in HOLD, and the pending result SHALL be discarded.
REQ-034 The first post-reset transaction SHALL assert mul_clr before any mul_en cycle.

Verification
REQ-035 a=512, b=256, mul_ov driven high after 131072 RUN cycles, mul_z=131072 -> out_z=131072, out_cycles=131072, out_timeout=0, out_valid at T+131075.
REQ-036 a=0, b=700 -> out_valid at T+1, out_z=0, out_cycles=0, no mul_clr/mul_en pulse.
REQ-037 MAX_CYCLES=16, mul_ov held low -> DRAIN after 16 RUN cycles, out_timeout=1, out_cycles=16.
REQ-038 out_ready held low 5 cycles in HOLD while in_valid=1 with new operands -> out_* stable, in_ready=0, new operands not latched; acceptance occurs only after IDLE re-entry.
REQ-039 rst pulsed in RUN cycle 3 -> next edge IDLE, mul_en=0, out_valid=0; next transaction starts with a one-cycle mul_clr pulse.
REQ-040 mul_ov high on the same cycle as the watchdog limit -> out_timeout=0; mul_ov pulses in IDLE/HOLD -> no state change.
